// File: rtl/st2cl_packer_v2.sv
// st2cl_packer_v2: packs ST_W-bit stream beats into CL-bit cache lines with a 16-bit header.
// Latency: the line completed by the beat accepted at edge E is written at the first edge E+n (n>=1) with source_ready=1.
// Backpressure: a single holding register. sink_ready drops only when a completing beat would find the holder full and not draining.
//
// Ports: clk, rst_n_sync (async, active-low); sink_data/valid/sop/eop -> sink_ready (stream side);
//        source_ready -> ff_wrreq/ff_data (line write side); ff_wr_finish pulses once per packet.
// Optional feature: define ST2CL_SEQ_EN to stamp a 4-bit packet sequence number into header bits [CL-1:CL-4].
module st2cl_packer_v2 #(
  parameter int CL         = 512,
  parameter int CL_HEAD    = 16,
  parameter int CL_PAYLOAD = 496,
  parameter int ST_W       = 8,
  parameter int MAX_ST     = 41,
  parameter int W_LEN      = 10
) (
  input  logic            clk,
  input  logic            rst_n_sync,
  input  logic [ST_W-1:0] sink_data,
  input  logic            sink_valid,
  input  logic            sink_sop,
  input  logic            sink_eop,
  output logic            sink_ready,
  input  logic            source_ready,
  output logic            ff_wrreq,
  output logic [CL-1:0]   ff_data,
  output logic            ff_wr_finish
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_FIN} state_t;

  localparam logic [W_LEN-1:0] LAST_SLOT = W_LEN'(MAX_ST - 1);

  state_t                state_q;
  logic [W_LEN-1:0]      cnt_q;
  logic [CL_PAYLOAD-1:0] acc_q;
  logic [CL-1:0]         hold_q;
  logic                  hold_vld_q;
  logic                  sop_flag_q;
  logic                  pkt_open_q;
  logic                  ff_wrreq_q;
  logic [CL-1:0]         ff_data_q;
  logic                  fin_q;
`ifdef ST2CL_SEQ_EN
  logic [3:0]            seq_q;
`endif

  logic                  cnt_last;
  logic                  drain;
  logic                  accept;
  logic                  line_done;
  logic                  beat_sop;
  logic [CL_PAYLOAD-1:0] slot;
  logic [CL_PAYLOAD-1:0] payload_d;
  logic [CL-1:0]         line_d;

  always_comb begin
    cnt_last  = (cnt_q == LAST_SLOT);
    drain     = hold_vld_q && source_ready;
    // Any completing beat (last slot or eop) needs the holder free or draining
    // this edge; non-completing beats only touch the accumulator.
    sink_ready = (state_q == S_RUN) &&
                 (!hold_vld_q || source_ready || (!cnt_last && !sink_eop));
    accept    = sink_valid && sink_ready;
    line_done = accept && (cnt_last || sink_eop);
    // A second sop inside an open packet is ignored.
    beat_sop  = sink_sop && !pkt_open_q;
    // Accumulator slots above cnt are always zero, so OR-ing the beat in
    // both places it and leaves the unused tail zero-padded.
    slot      = {{(CL_PAYLOAD-ST_W){1'b0}}, sink_data};
    payload_d = acc_q | (slot << (int'(cnt_q) * ST_W));

    line_d                         = '0;
    line_d[CL_PAYLOAD-1:0]         = payload_d;
    line_d[CL-5]                   = sop_flag_q || beat_sop;
    line_d[CL-6]                   = sink_eop;
    line_d[CL-CL_HEAD +: W_LEN]    = cnt_q + W_LEN'(1);
`ifdef ST2CL_SEQ_EN
    line_d[CL-1 -: 4]              = seq_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      sop_flag_q <= 1'b0;
      pkt_open_q <= 1'b0;
      ff_wrreq_q <= 1'b0;
      ff_data_q  <= '0;
      fin_q      <= 1'b0;
`ifdef ST2CL_SEQ_EN
      seq_q      <= '0;
`endif
    end else begin
      // Output write port: one strobe per drained line, data held otherwise.
      ff_wrreq_q <= drain;
      if (drain) ff_data_q <= hold_q;

      // A reload on the drain edge keeps hold_vld_q set.
      if (line_done) begin
        hold_q     <= line_d;
        hold_vld_q <= 1'b1;
      end else if (drain) begin
        hold_vld_q <= 1'b0;
      end

      if (accept) begin
        if (line_done) begin
          acc_q      <= '0;
          cnt_q      <= '0;
          sop_flag_q <= 1'b0;
        end else begin
          acc_q <= payload_d;
          cnt_q <= cnt_q + W_LEN'(1);
          if (beat_sop) sop_flag_q <= 1'b1;
        end
        pkt_open_q <= sink_eop ? 1'b0 : (pkt_open_q || sink_sop);
      end

      fin_q <= 1'b0;
      case (state_q)
        S_IDLE:  if (source_ready) state_q <= S_RUN;
        S_RUN:   if (accept && sink_eop) state_q <= S_FLUSH;
        // The eop line entered the holder on the RUN->FLUSH edge; finish
        // once it has been written out.
        S_FLUSH: if (!hold_vld_q) begin
                   state_q <= S_FIN;
                   fin_q   <= 1'b1;
                 end
        S_FIN: begin
          state_q <= S_IDLE;
`ifdef ST2CL_SEQ_EN
          seq_q   <= seq_q + 4'd1;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ff_wrreq     = ff_wrreq_q;
  assign ff_data      = ff_data_q;
  assign ff_wr_finish = fin_q;

endmodule
